// File: rtl/decade_counter_if.sv
// Bus bundle for one BCD counter digit: run/hold control in, count and carry out.
// Latency: none, this is wiring only.
// Backpressure: none; the carry output is the only flow signal and feeds the next digit's enable.
interface decade_counter_if #(
    parameter int unsigned COUNT_WIDTH = 4
);
    logic                   Start_Stopb_In;
    logic [COUNT_WIDTH-1:0] Count_Out;
    logic                   Carry_Out;

    // Counter side: takes the enable, drives count and carry.
    modport slave (
        input  Start_Stopb_In,
        output Count_Out,
        output Carry_Out
    );

    // Controller / next-digit side: drives the enable, observes count and carry.
    modport master (
        output Start_Stopb_In,
        input  Count_Out,
        input  Carry_Out
    );
endinterface

// File: rtl/decade_counter.sv
// Modulo-10 BCD up-counter with run/hold enable and terminal-count carry for cascading.
// Latency: count changes one edge after the enable is sampled high; carry is combinational.
// Backpressure: Start_Stopb_In low holds the count; carry is gated by the enable and by reset.
module decade_counter #(
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned COUNT_MAX   = 9
) (
    input  logic                 Clk_In,
    input  logic                 Reset_In,
    decade_counter_if.slave      cnt_if
);

    localparam logic [COUNT_WIDTH-1:0] MAX_VAL = COUNT_WIDTH'(COUNT_MAX);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Next count: advance while enabled; the terminal value and any illegal
    // value above it both load zero, so a corrupted digit self-recovers on the
    // next enabled edge and otherwise just holds.
    always_comb begin
        count_d = count_q;
        if (cnt_if.Start_Stopb_In) begin
            if (count_q >= MAX_VAL) begin
                count_d = '0;
            end else begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Count register; reset clears it immediately without waiting for a clock.
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cnt_if.Count_Out = count_q;

    // Carry marks the cycle before the wrap. Illegal values never equal
    // MAX_VAL, so carry stays low for them. Reset gates it directly so it is
    // low even in the instant reset falls.
    assign cnt_if.Carry_Out = (count_q == MAX_VAL) && cnt_if.Start_Stopb_In && Reset_In;

endmodule

// File: tb/tb_decade_counter.sv
module tb_decade_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    decade_counter_if #(.COUNT_WIDTH(4)) dut_if ();

    decade_counter #(
        .COUNT_WIDTH(4),
        .COUNT_MAX  (9)
    ) dut (
        .Clk_In  (clk),
        .Reset_In(rst_n),
        .cnt_if  (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       exp_carry;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic c, input logic [3:0] n);
        vec_t v;
        v.start     = s;
        v.exp_carry = c;
        v.exp_count = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   exp_n;
        bit   wrapped;
        logic [3:0] prev;

        checks = 0;
        errors = 0;

        // Table: each record sets the enable, checks carry for the current
        // count, then checks the count after the next edge.
        // Full sequence from 0: 1..9 then wrap, carry only while at 9.
        add(1, 0, 1); add(1, 0, 2); add(1, 0, 3); add(1, 0, 4); add(1, 0, 5);
        add(1, 0, 6); add(1, 0, 7); add(1, 0, 8); add(1, 0, 9); add(1, 1, 0);
        // Count to 4, hold for 5 edges, resume to 5.
        add(1, 0, 1); add(1, 0, 2); add(1, 0, 3); add(1, 0, 4);
        add(0, 0, 4); add(0, 0, 4); add(0, 0, 4); add(0, 0, 4); add(0, 0, 4);
        add(1, 0, 5);
        // Count to 9, hold at terminal count (carry low), resume to wrap.
        add(1, 0, 6); add(1, 0, 7); add(1, 0, 8); add(1, 0, 9);
        add(0, 0, 9); add(0, 0, 9); add(0, 0, 9);
        add(1, 1, 0);

        // Reset asserted mid-cycle with enable high.
        rst_n = 1'b1;
        dut_if.Start_Stopb_In = 1'b1;
        #12;
        rst_n = 1'b0;
        #1;
        check("reset_count_immediate", {28'd0, dut_if.Count_Out}, 32'd0);
        check("reset_carry_immediate", {31'd0, dut_if.Carry_Out}, 32'd0);
        step();
        step();
        check("reset_count_held", {28'd0, dut_if.Count_Out}, 32'd0);
        check("reset_carry_held", {31'd0, dut_if.Carry_Out}, 32'd0);

        // Release between edges; the table then drives from count 0.
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            dut_if.Start_Stopb_In = vecs[i].start;
            #1;
            check($sformatf("vec%0d_carry", i), {31'd0, dut_if.Carry_Out}, {31'd0, vecs[i].exp_carry});
            step();
            check($sformatf("vec%0d_count", i), {28'd0, dut_if.Count_Out}, {28'd0, vecs[i].exp_count});
        end

        // Asynchronous reset mid-count at 7.
        dut_if.Start_Stopb_In = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("async_pre_count", {28'd0, dut_if.Count_Out}, 32'd7);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_count_cleared", {28'd0, dut_if.Count_Out}, 32'd0);
        check("async_carry_low", {31'd0, dut_if.Carry_Out}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("async_release_first", {28'd0, dut_if.Count_Out}, 32'd1);

        // Long run: 15 edges enabled, count stays in range and wraps.
        exp_n   = 1;
        wrapped = 1'b0;
        for (int i = 0; i < 15; i++) begin
            prev = dut_if.Count_Out;
            step();
            exp_n = (exp_n + 1) % 10;
            check($sformatf("long%0d_count", i), {28'd0, dut_if.Count_Out}, exp_n);
            check($sformatf("long%0d_range", i), {31'd0, (dut_if.Count_Out <= 4'd9)}, 32'd1);
            if (prev == 4'd9 && dut_if.Count_Out == 4'd0) wrapped = 1'b1;
        end
        check("long_wrapped", {31'd0, wrapped}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
